// File: rtl/tdma_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : tdma_slot_timer
// Brief    : TDMA slot timebase for the control-station bus. Produces a slot
//            start pulse and the current slot number, free-running after
//            start_token or aligned to received slot markers while joining.
//            Define SLOT_WDOG_EN to build the lost-token watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tdma_slot_timer #(
    parameter int          SLOT_CYCLES = 2500,
    parameter logic [7:0]  MAX_ID_SLOT = 8'd71,
    parameter logic [15:0] WDOG_SLOTS  = 16'd144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_token,
    input  logic       join_en,
    input  logic       halt,
    input  logic       rx_sync,
    input  logic [7:0] rx_slot_id,
    input  logic [7:0] own_slot,
    output logic       flag_slot_start,
    output logic [7:0] id_slot,
    output logic       cycle_start,
    output logic       tx_window,
    output logic       running,
    output logic       sync_err,
    output logic       token_lost
);

    localparam logic [0:0]  c_IDLE      = 1'b0;
    localparam logic [0:0]  c_RUN       = 1'b1;
    localparam logic [15:0] c_TICK_LAST = 16'(SLOT_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [7:0]  id_slot_q, id_slot_d;
    logic        flag_q, flag_d;
    logic        cycle_q, cycle_d;
    logic        tx_q, tx_d;
    logic        serr_q, serr_d;
    logic        tlost_q, tlost_d;

    logic        w_rx_valid;
    logic        w_rx_bad;
    logic        w_accept;
    logic [7:0]  w_next_id;
    logic        w_wdog_expired;

    assign w_rx_valid = rx_sync && (rx_slot_id <= MAX_ID_SLOT);
    assign w_rx_bad   = rx_sync && (rx_slot_id > MAX_ID_SLOT);
    assign w_accept   = join_en && w_rx_valid;
    // >= so that a corrupted slot number falls back into range at the next wrap
    assign w_next_id  = (id_slot_q >= MAX_ID_SLOT) ? 8'd0 : id_slot_q + 8'd1;

`ifdef SLOT_WDOG_EN
    logic [15:0] wdog_q, wdog_d;

    assign w_wdog_expired = (state_q == c_RUN) && (wdog_q >= WDOG_SLOTS);

    always_comb begin
        wdog_d = wdog_q;
        if (halt || (state_d == c_IDLE)) begin
            wdog_d = 16'd0;
        end else if (start_token || w_accept) begin
            wdog_d = 16'd0;
        end else if ((state_q == c_RUN) && flag_d) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic w_unused_wdog;

    assign w_unused_wdog  = ^WDOG_SLOTS;
    assign w_wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        id_slot_d = id_slot_q;
        flag_d    = 1'b0;
        serr_d    = 1'b0;
        tlost_d   = 1'b0;
        if (halt) begin
            state_d   = c_IDLE;
            tick_d    = 16'd0;
            id_slot_d = 8'd0;
        end else begin
            serr_d = w_rx_bad;
            if (start_token) begin
                state_d   = c_RUN;
                tick_d    = 16'd0;
                id_slot_d = 8'd0;
                flag_d    = 1'b1;
            end else if (w_accept) begin
                // Resync overrides a coincident natural wrap: one pulse only
                state_d   = c_RUN;
                tick_d    = 16'd0;
                id_slot_d = rx_slot_id;
                flag_d    = 1'b1;
            end else if (state_q == c_RUN) begin
                if (w_wdog_expired) begin
                    state_d   = c_IDLE;
                    tick_d    = 16'd0;
                    id_slot_d = 8'd0;
                    tlost_d   = 1'b1;
                end else if (tick_q >= c_TICK_LAST) begin
                    tick_d    = 16'd0;
                    id_slot_d = w_next_id;
                    flag_d    = 1'b1;
                end else begin
                    tick_d    = tick_q + 16'd1;
                end
            end
        end
        cycle_d = flag_d && (id_slot_d == 8'd0);
        tx_d    = (state_d == c_RUN) && (id_slot_d == own_slot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            tick_q    <= 16'd0;
            id_slot_q <= 8'd0;
            flag_q    <= 1'b0;
            cycle_q   <= 1'b0;
            tx_q      <= 1'b0;
            serr_q    <= 1'b0;
            tlost_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            id_slot_q <= id_slot_d;
            flag_q    <= flag_d;
            cycle_q   <= cycle_d;
            tx_q      <= tx_d;
            serr_q    <= serr_d;
            tlost_q   <= tlost_d;
        end
    end

    assign flag_slot_start = flag_q;
    assign id_slot         = id_slot_q;
    assign cycle_start     = cycle_q;
    assign tx_window       = tx_q;
    assign running         = (state_q == c_RUN);
    assign sync_err        = serr_q;
    assign token_lost      = tlost_q;

endmodule
`default_nettype wire

// File: tb/tb_tdma_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdma_slot_timer
// Brief    : Directed self-checking bench for tdma_slot_timer
//            (SLOT_CYCLES=10, MAX_ID_SLOT=3, WDOG_SLOTS=4, own_slot=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdma_slot_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_token = 1'b0;
    logic       join_en = 1'b0;
    logic       halt = 1'b0;
    logic       rx_sync = 1'b0;
    logic [7:0] rx_slot_id = 8'd0;
    logic [7:0] own_slot = 8'd2;
    logic       flag_slot_start;
    logic [7:0] id_slot;
    logic       cycle_start;
    logic       tx_window;
    logic       running;
    logic       sync_err;
    logic       token_lost;

    int n_checks = 0;
    int n_errors = 0;

    tdma_slot_timer #(
        .SLOT_CYCLES (10),
        .MAX_ID_SLOT (8'd3),
        .WDOG_SLOTS  (16'd4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start_token     (start_token),
        .join_en         (join_en),
        .halt            (halt),
        .rx_sync         (rx_sync),
        .rx_slot_id      (rx_slot_id),
        .own_slot        (own_slot),
        .flag_slot_start (flag_slot_start),
        .id_slot         (id_slot),
        .cycle_start     (cycle_start),
        .tx_window       (tx_window),
        .running         (running),
        .sync_err        (sync_err),
        .token_lost      (token_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the next slot pulse (bounded) and checks its gap and contents;
    // tx_window must stay constant between pulses.
    task automatic wait_pulse(input string tag, input logic [7:0] eid, input int egap,
                              input logic ecyc, input logic etx);
        int   n = 0;
        bit   seen = 0;
        int   txbad = 0;
        logic txhold;
        txhold = tx_window;
        while (!seen && n < 40) begin
            step();
            n++;
            if (flag_slot_start) seen = 1;
            else if (tx_window !== txhold) txbad++;
        end
        chk({tag, "_gap"}, n, egap);
        chk({tag, "_id"}, {24'd0, id_slot}, {24'd0, eid});
        chk({tag, "_cyc"}, {31'd0, cycle_start}, {31'd0, ecyc});
        chk({tag, "_tx"}, {31'd0, tx_window}, {31'd0, etx});
        chk({tag, "_txhold"}, txbad, 0);
    endtask

    initial begin
        int act;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_flag", {31'd0, flag_slot_start}, 0);
        chk("rst_id", {24'd0, id_slot}, 0);
        chk("rst_run", {31'd0, running}, 0);
        chk("rst_tx", {31'd0, tx_window}, 0);
        chk("rst_misc", {29'd0, cycle_start, sync_err, token_lost}, 0);

        // Free-running start from start_token
        start_token = 1'b1;
        step();
        start_token = 1'b0;
        chk("st_flag", {31'd0, flag_slot_start}, 1);
        chk("st_cyc", {31'd0, cycle_start}, 1);
        chk("st_id", {24'd0, id_slot}, 0);
        chk("st_run", {31'd0, running}, 1);
        chk("st_tx", {31'd0, tx_window}, 0);
        wait_pulse("s1", 8'd1, 10, 1'b0, 1'b0);
        wait_pulse("s2", 8'd2, 10, 1'b0, 1'b1);
        wait_pulse("s3", 8'd3, 10, 1'b0, 1'b0);
        wait_pulse("s0", 8'd0, 10, 1'b1, 1'b0);

        // Halt mid-slot, then start_token together with halt
        repeat (3) step();
        halt = 1'b1;
        step();
        chk("halt_run", {31'd0, running}, 0);
        chk("halt_id", {24'd0, id_slot}, 0);
        chk("halt_flag", {31'd0, flag_slot_start}, 0);
        act = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (flag_slot_start || running || tx_window) act++;
        end
        chk("halt_quiet", act, 0);
        start_token = 1'b1;
        step();
        chk("halt_st_run", {31'd0, running}, 0);
        chk("halt_st_flag", {31'd0, flag_slot_start}, 0);
        start_token = 1'b0;
        halt = 1'b0;
        step();
        chk("halt_rel_run", {31'd0, running}, 0);

        // Join from IDLE on a valid marker
        join_en = 1'b1;
        rx_sync = 1'b1;
        rx_slot_id = 8'd2;
        step();
        rx_sync = 1'b0;
        chk("join_flag", {31'd0, flag_slot_start}, 1);
        chk("join_id", {24'd0, id_slot}, 2);
        chk("join_run", {31'd0, running}, 1);
        chk("join_cyc", {31'd0, cycle_start}, 0);
        chk("join_tx", {31'd0, tx_window}, 1);
        wait_pulse("j3", 8'd3, 10, 1'b0, 1'b0);
        wait_pulse("j0", 8'd0, 10, 1'b1, 1'b0);
        wait_pulse("j1", 8'd1, 10, 1'b0, 1'b0);

        // Resync at the last tick of slot 1 to slot 3
        repeat (9) step();
        rx_sync = 1'b1;
        rx_slot_id = 8'd3;
        step();
        rx_sync = 1'b0;
        chk("rs_flag", {31'd0, flag_slot_start}, 1);
        chk("rs_id", {24'd0, id_slot}, 3);
        step();
        chk("rs_single", {31'd0, flag_slot_start}, 0);
        wait_pulse("rs0", 8'd0, 9, 1'b1, 1'b0);

        // Invalid marker: sync_err only, timing untouched
        repeat (3) step();
        rx_sync = 1'b1;
        rx_slot_id = 8'd4;
        step();
        rx_sync = 1'b0;
        chk("bad_serr", {31'd0, sync_err}, 1);
        chk("bad_flag", {31'd0, flag_slot_start}, 0);
        chk("bad_id", {24'd0, id_slot}, 0);
        step();
        chk("bad_serr_off", {31'd0, sync_err}, 0);
        wait_pulse("bad1", 8'd1, 5, 1'b0, 1'b0);

        // Marker with join_en low from IDLE is ignored
        halt = 1'b1;
        step();
        halt = 1'b0;
        join_en = 1'b0;
        rx_sync = 1'b1;
        rx_slot_id = 8'd2;
        step();
        rx_sync = 1'b0;
        act = 0;
        for (int i = 0; i < 15; i++) begin
            if (flag_slot_start || running || tx_window || sync_err || id_slot != 8'd0) act++;
            step();
        end
        chk("nojoin_quiet", act, 0);

        // Watchdog, or free-run for 100 slots without it
        start_token = 1'b1;
        step();
        start_token = 1'b0;
        chk("wd_st_flag", {31'd0, flag_slot_start}, 1);
`ifdef SLOT_WDOG_EN
        wait_pulse("w1", 8'd1, 10, 1'b0, 1'b0);
        wait_pulse("w2", 8'd2, 10, 1'b0, 1'b1);
        wait_pulse("w3", 8'd3, 10, 1'b0, 1'b0);
        wait_pulse("w0", 8'd0, 10, 1'b1, 1'b0);
        step();
        chk("wd_lost", {31'd0, token_lost}, 1);
        chk("wd_id", {24'd0, id_slot}, 0);
        step();
        chk("wd_lost_off", {31'd0, token_lost}, 0);
        chk("wd_run", {31'd0, running}, 0);
`else
        act = 0;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] eid;
            eid = 8'((i + 1) % 4);
            wait_pulse("fr", eid, 10, eid == 8'd0, eid == 8'd2);
            if (token_lost) act++;
        end
        chk("fr_nolost", act, 0);
        chk("fr_run", {31'd0, running}, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
